ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Self-test sequencer that sits directly upstream of the 32x4 synchronous RAM and drives its address, write-data and write-enable inputs.
- Consumes the RAM's registered read data and runs a four-phase write/read-compare sweep.
- Reports pass/fail, the first failing address and a mismatch count, which feed the board's LEDs and 7-seg displays.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 4, RAM word width
DEPTH, 32, words swept per phase (2**ADDR_W)
PATTERN, 4'hA, XOR seed for generated data

Ports:
Clock  in  1  rising-edge clock
Resetn  in  1  asynchronous active-low reset
start  in  1  level sampled each edge; begins a run from IDLE or DONE
mem_addr  out  ADDR_W  RAM address, registered
mem_wdata  out  DATA_W  RAM write data, registered
mem_we  out  1  RAM write enable, registered
mem_rdata  in  DATA_W  RAM registered read data; write-first on the same edge
busy  out  1  high from the first op through drain
done  out  1  high in DONE
pass  out  1  valid when done=1; 1 means zero mismatches
fail_addr  out  ADDR_W  address of the first mismatch; 0 if none
err_count  out  7  total mismatches, 0..64

Behaviour:
- Reset (async, Resetn=0): state=IDLE; mem_we, mem_addr, mem_wdata, busy, done, pass, fail_addr, err_count and all pipeline flags = 0. mem_we falls immediately, without waiting for a clock edge.
- Data function: d(a) = a[3:0] ^ PATTERN.
- States: IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE.
  - IDLE/DONE: start=1 -> WR0 with addr=0. Entry clears err_count, fail_addr, pass, done.
  - WR0: mem_we=1, wdata=d(addr).
  - RD0: mem_we=0; expected value = d(addr).
  - WR1: mem_we=1, wdata=~d(addr).
  - RD1: mem_we=0; expected value = ~d(addr).
  - Each phase issues addr 0..31 ascending, one op per cycle. At addr=31 the address wraps to 0 and the state advances: WR0->RD0->WR1->RD1->DRAIN.
  - DRAIN lasts 2 cycles with mem_we=0 and mem_addr=0, then -> DONE.
  - DONE: done=1, busy=0; holds until start or reset.
- Read pipeline:
  - rd_iss is registered alongside mem_addr, together with exp_iss.
  - On every edge, chk_v<=rd_iss and exp_q<=exp_iss; a_q holds the issued address.
  - On an edge with chk_v=1, compare mem_rdata against exp_q.
  - Compare latency is 2 edges after the controller registers the op. Compares carry over into the next phase and into DRAIN.
- Timing: start sampled at edge S. Ops are sampled by the RAM at edges S+1..S+128. The last compare happens at S+129, and done=1 from S+130. busy=1 from S through S+129.
- Mismatch handling: err_count+1. If this is the first mismatch of the run, fail_addr<=a_q. pass<=(err_count==0) is set on DONE entry.
- start while busy is ignored. start held high in DONE restarts immediately.
- Reset mid-run discards everything. RAM contents are undefined afterwards, which is acceptable.

Decomposition:
- Shared package holds:
  - state enum (3-bit)
  - DEPTH, CMP_LAT=2, DRAIN_CYC=2
  - the d(a) data function
- No sub-module. The RAM stays a separate instance; the bench uses a behavioural write-first registered RAM model.

Test Plan:
- Reset: hold Resetn=0 for 3 cycles, release -> all outputs 0, state IDLE, mem_we=0.
- Clean run, PATTERN=A: pulse start -> at addr 5 WR0 writes 4'hF and WR1 writes 4'h0; done=1 exactly 130 edges after S; pass=1, err_count=0, fail_addr=0.
- Stuck-at: model forces addr 7 bit0=0 -> RD0 expects D and reads C (mismatch); RD1 expects 2 and reads 2 (match) -> pass=0, fail_addr=7, err_count=1.
- Dead RAM: mem_rdata forced 0 -> err_count=60 (expected-zero cases at addr 10/26 in RD0 and 5/21 in RD1 match), fail_addr=0, pass=0.
- Start handling: start re-pulsed at S+40 -> ignored, done still at S+130; start at DONE -> results cleared, second clean run reproduces identical timing.
- Async reset: Resetn low mid-WR1 (addr 12) between edges -> mem_we=0 and busy=0 before the next edge; after release, a start gives a clean full run.

Source files
------------

// File: rtl/ram_bist_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl_pkg
// Shared definitions for the RAM self-test sequencer: geometry of the 32x4
// RAM under test, pipeline/drain lengths, the sequencer state encoding and
// the generated test-data function d(a) = a[3:0] ^ PATTERN.
// ---------------------------------------------------------------------------
package ram_bist_ctrl_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 4;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned ERR_W     = 7;
  localparam logic [3:0]  PATTERN   = 4'hA;

  // Edges from the controller registering a read op to the compare edge.
  localparam int unsigned CMP_LAT   = 2;
  // Cycles spent after the last op so the final compares can retire.
  localparam int unsigned DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR0   = 3'd1,
    ST_RD0   = 3'd2,
    ST_WR1   = 3'd3,
    ST_RD1   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } bist_state_e;

  // Test data written in the true phase; the complement phase uses ~d(a).
  function automatic logic [DATA_W-1:0] bist_data(input logic [ADDR_W-1:0] addr);
    return addr[DATA_W-1:0] ^ PATTERN;
  endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl_if
// Port bundle between the self-test sequencer and the synchronous RAM.
//   mem_addr  : RAM address           (sequencer -> RAM)
//   mem_wdata : RAM write data        (sequencer -> RAM)
//   mem_we    : RAM write enable      (sequencer -> RAM)
//   mem_rdata : RAM registered read   (RAM -> sequencer), write-first
// Modports: master = sequencer side, slave = RAM side.
// ---------------------------------------------------------------------------
interface ram_bist_ctrl_if
  import ram_bist_ctrl_pkg::*;
();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl
// Self-test sequencer for the 32x4 synchronous RAM. On start it sweeps four
// phases (write d(a), read/compare d(a), write ~d(a), read/compare ~d(a)),
// one op per cycle over addresses 0..31, drains the read pipeline for two
// cycles and then reports the result until the next start.
//
// Ports:
//   Clock     in   rising-edge clock
//   Resetn    in   asynchronous active-low reset
//   start     in   level; begins a run from IDLE or DONE, ignored while busy
//   mem       if   RAM bus (master): registered addr/wdata/we, read data in
//   busy      out  high from the first op through the drain cycles
//   done      out  high while in DONE
//   pass      out  valid with done; 1 when the run saw no mismatch
//   fail_addr out  address of the first mismatch of the run, 0 if none
//   err_count out  number of mismatches in the run (0..64)
// ---------------------------------------------------------------------------
module ram_bist_ctrl
  import ram_bist_ctrl_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 start,
  ram_bist_ctrl_if.master      mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
  localparam logic [1:0]        DRAIN_LAST = 2'(DRAIN_CYC - 1);
  localparam logic [ERR_W-1:0]  ERR_ZERO   = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]  ERR_ONE    = ERR_W'(1);

  // Sequencer state; state_r describes the op currently on the RAM bus.
  bist_state_e       state_r;
  bist_state_e       state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic [1:0]        drain_cnt_r;
  logic [1:0]        drain_cnt_s;
  logic              run_clear_s;

  // Registered RAM drive and issue-side read tags.
  logic              we_r;
  logic              we_s;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] wdata_s;
  logic              rd_iss_r;
  logic              rd_iss_s;
  logic [DATA_W-1:0] exp_iss_r;
  logic [DATA_W-1:0] exp_iss_s;
  logic              busy_r;
  logic              busy_s;

  // Compare stage: aligned with the RAM's registered read data.
  logic              chk_v_r;
  logic [DATA_W-1:0] exp_q_r;
  logic [ADDR_W-1:0] a_q_r;
  logic              mismatch_s;

  // Run results.
  logic              done_r;
  logic              pass_r;
  logic [ADDR_W-1:0] fail_addr_r;
  logic [ERR_W-1:0]  err_count_r;

  // Next-state, next-address and next bus values. Bus outputs are computed
  // from the next state so that they leave the flops together with it.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    drain_cnt_s = drain_cnt_r;
    run_clear_s = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s     = ST_WR0;
          addr_s      = ADDR_ZERO;
          run_clear_s = 1'b1;
        end else begin
          state_s     = state_r;
        end
      end
      ST_WR0, ST_RD0, ST_WR1, ST_RD1: begin
        if (addr_r == ADDR_LAST) begin
          addr_s      = ADDR_ZERO;
          drain_cnt_s = 2'd0;
          case (state_r)
            ST_WR0:  state_s = ST_RD0;
            ST_RD0:  state_s = ST_WR1;
            ST_WR1:  state_s = ST_RD1;
            default: state_s = ST_DRAIN;
          endcase
        end else begin
          addr_s = addr_r + ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_s     = ST_DONE;
          drain_cnt_s = 2'd0;
        end else begin
          drain_cnt_s = drain_cnt_r + 2'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        addr_s  = ADDR_ZERO;
      end
    endcase

    we_s      = 1'b0;
    wdata_s   = DATA_ZERO;
    rd_iss_s  = 1'b0;
    exp_iss_s = DATA_ZERO;
    busy_s    = 1'b0;

    case (state_s)
      ST_WR0: begin
        we_s    = 1'b1;
        wdata_s = bist_data(addr_s);
        busy_s  = 1'b1;
      end
      ST_RD0: begin
        rd_iss_s  = 1'b1;
        exp_iss_s = bist_data(addr_s);
        busy_s    = 1'b1;
      end
      ST_WR1: begin
        we_s    = 1'b1;
        wdata_s = ~bist_data(addr_s);
        busy_s  = 1'b1;
      end
      ST_RD1: begin
        rd_iss_s  = 1'b1;
        exp_iss_s = ~bist_data(addr_s);
        busy_s    = 1'b1;
      end
      ST_DRAIN: begin
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered RAM drive; reset drops mem_we at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r     <= ST_IDLE;
      addr_r      <= ADDR_ZERO;
      drain_cnt_r <= 2'd0;
      we_r        <= 1'b0;
      wdata_r     <= DATA_ZERO;
      rd_iss_r    <= 1'b0;
      exp_iss_r   <= DATA_ZERO;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      drain_cnt_r <= drain_cnt_s;
      we_r        <= we_s;
      wdata_r     <= wdata_s;
      rd_iss_r    <= rd_iss_s;
      exp_iss_r   <= exp_iss_s;
      busy_r      <= busy_s;
    end
  end

  // A read issued at edge E is sampled by the RAM at E+1, so the tag moves
  // one stage and meets the RAM's registered data at E+2.
  always_comb begin
    if (chk_v_r && (mem.mem_rdata != exp_q_r)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Compare pipeline and result accumulation.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      chk_v_r     <= 1'b0;
      exp_q_r     <= DATA_ZERO;
      a_q_r       <= ADDR_ZERO;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_addr_r <= ADDR_ZERO;
      err_count_r <= ERR_ZERO;
    end else begin
      chk_v_r <= rd_iss_r;
      exp_q_r <= exp_iss_r;
      a_q_r   <= addr_r;
      done_r  <= (state_s == ST_DONE);

      if (run_clear_s) begin
        pass_r      <= 1'b0;
        fail_addr_r <= ADDR_ZERO;
        err_count_r <= ERR_ZERO;
      end else if (mismatch_s) begin
        err_count_r <= err_count_r + ERR_ONE;
        if (err_count_r == ERR_ZERO) begin
          fail_addr_r <= a_q_r;
        end
      end

      // All compares have retired by the time DRAIN hands over to DONE.
      if ((state_r == ST_DRAIN) && (state_s == ST_DONE)) begin
        pass_r <= (err_count_r == ERR_ZERO);
      end
    end
  end

  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign mem.mem_we    = we_r;

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_addr = fail_addr_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_ctrl
// Bench for ram_bist_ctrl: a behavioural write-first registered 32x4 RAM
// with injectable faults (single stuck bit, or dead read port), directed
// runs from the test plan plus randomized fault/gap/re-start runs. Expected
// results come from a sweep-level reference model of the four phases.
// ---------------------------------------------------------------------------
module tb_ram_bist_ctrl;
  import ram_bist_ctrl_pkg::*;

  logic       Clock;
  logic       Resetn;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_addr;
  logic [6:0] err_count;

  ram_bist_ctrl_if bus ();

  ram_bist_ctrl dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .start     (start),
    .mem       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .err_count (err_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Fault injection: 0 = good RAM, 1 = one stuck cell bit, 2 = read data 0.
  int         fault_mode = 0;
  logic [4:0] f_addr     = 5'd0;
  int         f_bit      = 0;
  logic       f_val      = 1'b0;

  logic [3:0] ram_q [32];
  logic [8:0] wr_log [$];

  function automatic logic [3:0] cell_val(input logic [4:0] a, input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (fault_mode == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  // Behavioural RAM: registered read, write-first, plus a log of every write.
  always @(posedge Clock) begin
    if (bus.mem_we) begin
      ram_q[bus.mem_addr] <= cell_val(bus.mem_addr, bus.mem_wdata);
      bus.mem_rdata <= (fault_mode == 2) ? 4'h0 : cell_val(bus.mem_addr, bus.mem_wdata);
      wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    end else begin
      bus.mem_rdata <= (fault_mode == 2) ? 4'h0 : ram_q[bus.mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_d(input int a);
    logic [3:0] lo;
    lo = 4'(a % 16);
    return lo ^ 4'hA;
  endfunction

  // Whole-run reference: write every cell, then read every cell, twice.
  task automatic ref_model(input int mode, input int sa, input int sb, input int sv,
                           output int e_err, output int e_fail);
    logic [3:0] cells [32];
    logic [3:0] want;
    logic [3:0] seen;
    e_err  = 0;
    e_fail = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 32; a++) begin
        want = (ph == 0) ? ref_d(a) : ~ref_d(a);
        if (mode == 1 && a == sa) want[sb] = sv[0];
        cells[a] = want;
      end
      for (int a = 0; a < 32; a++) begin
        want = (ph == 0) ? ref_d(a) : ~ref_d(a);
        seen = (mode == 2) ? 4'h0 : cells[a];
        if (seen != want) begin
          if (e_err == 0) e_fail = a;
          e_err++;
        end
      end
    end
  endtask

  // Drive start for one edge (S) and follow the run until done or timeout.
  task automatic run_bist(input bit repulse, output int done_edge, output int busy_cyc);
    done_edge = -1;
    busy_cyc  = 0;
    wr_log.delete();
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    check_eq("clr_err", 32'(err_count), 32'd0);
    check_eq("clr_fail", 32'(fail_addr), 32'd0);
    check_eq("clr_pass_done", {30'd0, pass, done}, 32'd0);
    if (busy) busy_cyc++;
    for (int k = 1; k <= 200; k++) begin
      if (repulse && k == 40) start = 1'b1;
      @(posedge Clock); #1;
      if (repulse && k == 40) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        done_edge = k;
        break;
      end
    end
  endtask

  task automatic do_run(input int mode, input int sa, input int sb, input int sv, input bit repulse);
    int e_err;
    int e_fail;
    int done_edge;
    int busy_cyc;
    int seq_bad;
    logic [8:0] want;
    fault_mode = mode;
    f_addr     = 5'(sa);
    f_bit      = sb;
    f_val      = sv[0];
    ref_model(mode, sa, sb, sv, e_err, e_fail);
    run_bist(repulse, done_edge, busy_cyc);
    check_eq("done_edge", 32'(done_edge), 32'(4 * DEPTH + CMP_LAT));
    check_eq("busy_cycles", 32'(busy_cyc), 32'(4 * DEPTH + CMP_LAT));
    check_eq("done_idle_bus", {30'd0, busy, bus.mem_we}, 32'd0);
    check_eq("err_count", 32'(err_count), 32'(e_err));
    check_eq("fail_addr", 32'(fail_addr), 32'(e_fail));
    check_eq("pass", 32'(pass), (e_err == 0) ? 32'd1 : 32'd0);
    check_eq("wr_count", 32'(wr_log.size()), 32'd64);
    seq_bad = 0;
    for (int i = 0; i < 64 && i < wr_log.size(); i++) begin
      want = {5'(i % 32), (i < 32) ? ref_d(i % 32) : ~ref_d(i % 32)};
      if (wr_log[i] !== want) seq_bad++;
    end
    check_eq("wr_sequence", 32'(seq_bad), 32'd0);
  endtask

  initial begin
    int mode;
    Resetn = 1'b0;
    start  = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge Clock);
    #1;
    check_eq("rst_outputs", {20'd0, busy, done, pass, fail_addr, err_count}, 32'd0);
    check_eq("rst_bus", {22'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'd0);
    Resetn = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check_eq("idle_no_start", {29'd0, busy, done, bus.mem_we}, 32'd0);

    // Clean run, spot-check the address-5 writes.
    do_run(0, 0, 0, 0, 1'b0);
    check_eq("wr0_addr5", 32'(wr_log.size() > 5 ? wr_log[5] : 9'h1FF), {23'd0, 5'd5, 4'hF});
    check_eq("wr1_addr5", 32'(wr_log.size() > 37 ? wr_log[37] : 9'h1FF), {23'd0, 5'd5, 4'h0});

    // Stuck-at-0 on bit 0 of address 7; restarted straight from DONE.
    do_run(1, 7, 0, 0, 1'b0);
    check_eq("stuck_err", 32'(err_count), 32'd1);
    check_eq("stuck_fail", 32'(fail_addr), 32'd7);

    // Dead read port.
    do_run(2, 0, 0, 0, 1'b0);
    check_eq("dead_err", 32'(err_count), 32'd60);
    check_eq("dead_fail", 32'(fail_addr), 32'd0);

    // Start re-pulsed mid-run must not disturb timing.
    do_run(0, 0, 0, 0, 1'b1);

    // Asynchronous reset in the middle of WR1 at address 12.
    fault_mode = 0;
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (76) @(posedge Clock);
    #1;
    check_eq("wr1_a12_bus", {22'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
             {22'd0, 1'b1, 5'd12, ~ref_d(12)});
    #2 Resetn = 1'b0;
    #1;
    check_eq("async_rst", {27'd0, bus.mem_we, busy, done, pass, 1'b0}, 32'd0);
    check_eq("async_rst_cnt", 32'(err_count), 32'd0);
    repeat (2) @(posedge Clock);
    #3 Resetn = 1'b1;
    @(posedge Clock); #1;
    do_run(0, 0, 0, 0, 1'b0);

    // Randomized faults, idle gaps and stray starts.
    for (int r = 0; r < 8; r++) begin
      mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 4)) @(posedge Clock);
      #1;
      do_run(mode, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
